// File: rtl/player_shot_collision_detector.sv
// -----------------------------------------------------------------------------
// player_shot_collision_detector
//
// Per-frame collision arbiter for the player shot. During the raster scan it
// watches the shot drawing request against the alien, shield and top-border
// drawing requests. It latches the first overlap of the frame, together with
// its target kind, alien type and pixel coordinates. At the next frame
// boundary it publishes the result:
//   - a one-cycle fireCollision pulse, which kills the shot,
//   - alienHit / shieldHit, held for the frame,
//   - hitX / hitY, held until the next collision,
//   - a saturating 4-digit BCD score.
//
// Ports
//   clk            system clock (single domain)
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle frame boundary strobe
//   pixelX/pixelY  current raster coordinates (11 bit)
//   newGame        one-cycle pulse: clear score and any pending hit
//   playerShotDR   shot drawing request (already gated by shot alive)
//   aliensDR       alien pixel at the raster position
//   alienType      alien type under the raster (valid with aliensDR)
//   shieldsDR      shield pixel at the raster position
//   topBorderDR    top border pixel at the raster position
//   fireCollision  one-cycle pulse: the shot collided in the previous frame
//   alienHit       last collision was an alien (held for the frame)
//   shieldHit      last collision was a shield (held for the frame)
//   hitX/hitY      coordinates of the first overlap pixel
//   score          BCD score, [15:12] is the most significant digit
// -----------------------------------------------------------------------------
module player_shot_collision_detector (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        newGame,
  input  logic        playerShotDR,
  input  logic        aliensDR,
  input  logic [1:0]  alienType,
  input  logic        shieldsDR,
  input  logic        topBorderDR,
  output logic        fireCollision,
  output logic        alienHit,
  output logic        shieldHit,
  output logic [10:0] hitX,
  output logic [10:0] hitY,
  output logic [15:0] score
);

  // LOCKED means a hit is pending for the current frame.
  typedef enum logic {
    SCAN   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    KIND_ALIEN  = 2'd0,
    KIND_SHIELD = 2'd1,
    KIND_BORDER = 2'd2
  } kind_t;

  // Point value of an alien type, as two BCD digits.
  function automatic logic [7:0] alien_points(input logic [1:0] t);
    logic [7:0] p;
    case (t)
      2'd0:    p = 8'h10;
      2'd1:    p = 8'h20;
      2'd2:    p = 8'h30;
      default: p = 8'h50;
    endcase
    return p;
  endfunction

  // Digit-serial BCD add with decimal carry from units through thousands.
  // A carry out of the thousands digit means the sum passed 9999, so the
  // result saturates there.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a,
                                              input logic [7:0]  pts);
    logic [15:0] b;
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    b = {8'h00, pts};
    r = 16'h0000;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    if (c) begin
      r = 16'h9999;
    end
    return r;
  endfunction

  state_t      state_q,     state_d;
  kind_t       pend_kind_q, pend_kind_d;
  logic [1:0]  pend_type_q, pend_type_d;
  logic [10:0] pend_x_q,    pend_x_d;
  logic [10:0] pend_y_q,    pend_y_d;
  logic        fire_q,      fire_d;
  logic        alien_hit_q, alien_hit_d;
  logic        shield_hit_q, shield_hit_d;
  logic [10:0] hit_x_q,     hit_x_d;
  logic [10:0] hit_y_q,     hit_y_d;
  logic [15:0] score_q,     score_d;

  logic overlap;
  logic can_capture;

  assign overlap = playerShotDR & (aliensDR | shieldsDR | topBorderDR);

  always_comb begin
    state_d      = state_q;
    pend_kind_d  = pend_kind_q;
    pend_type_d  = pend_type_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    fire_d       = 1'b0;
    alien_hit_d  = alien_hit_q;
    shield_hit_d = shield_hit_q;
    hit_x_d      = hit_x_q;
    hit_y_d      = hit_y_q;
    score_d      = score_q;
    can_capture  = (state_q == SCAN);

    if (newGame) begin
      // newGame wins over any frame transfer or overlap on the same cycle.
      state_d      = SCAN;
      pend_kind_d  = KIND_ALIEN;
      pend_type_d  = 2'd0;
      alien_hit_d  = 1'b0;
      shield_hit_d = 1'b0;
      score_d      = 16'h0000;
      can_capture  = 1'b0;
    end else begin
      if (startOfFrame) begin
        if (state_q == LOCKED) begin
          fire_d       = 1'b1;
          alien_hit_d  = (pend_kind_q == KIND_ALIEN);
          shield_hit_d = (pend_kind_q == KIND_SHIELD);
          hit_x_d      = pend_x_q;
          hit_y_d      = pend_y_q;
          if (pend_kind_q == KIND_ALIEN) begin
            score_d = bcd_add_sat(score_q, alien_points(pend_type_q));
          end
        end else begin
          alien_hit_d  = 1'b0;
          shield_hit_d = 1'b0;
        end
        // The boundary cycle already belongs to the new frame, so an overlap
        // here is captured after the old hit has been handed off.
        state_d     = SCAN;
        can_capture = 1'b1;
      end

      if (can_capture && overlap) begin
        state_d     = LOCKED;
        pend_type_d = alienType;
        pend_x_d    = pixelX;
        pend_y_d    = pixelY;
        if (aliensDR) begin
          pend_kind_d = KIND_ALIEN;
        end else if (shieldsDR) begin
          pend_kind_d = KIND_SHIELD;
        end else begin
          pend_kind_d = KIND_BORDER;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= SCAN;
      pend_kind_q  <= KIND_ALIEN;
      pend_type_q  <= 2'd0;
      pend_x_q     <= 11'd0;
      pend_y_q     <= 11'd0;
      fire_q       <= 1'b0;
      alien_hit_q  <= 1'b0;
      shield_hit_q <= 1'b0;
      hit_x_q      <= 11'd0;
      hit_y_q      <= 11'd0;
      score_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pend_kind_q  <= pend_kind_d;
      pend_type_q  <= pend_type_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      fire_q       <= fire_d;
      alien_hit_q  <= alien_hit_d;
      shield_hit_q <= shield_hit_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
      score_q      <= score_d;
    end
  end

  assign fireCollision = fire_q;
  assign alienHit      = alien_hit_q;
  assign shieldHit     = shield_hit_q;
  assign hitX          = hit_x_q;
  assign hitY          = hit_y_q;
  assign score         = score_q;

endmodule

// File: tb/tb_player_shot_collision_detector.sv
// -----------------------------------------------------------------------------
// Testbench for player_shot_collision_detector: directed scenarios plus
// randomized raster traffic compared against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_player_shot_collision_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        newGame;
  logic        playerShotDR;
  logic        aliensDR;
  logic [1:0]  alienType;
  logic        shieldsDR;
  logic        topBorderDR;
  logic        fireCollision;
  logic        alienHit;
  logic        shieldHit;
  logic [10:0] hitX;
  logic [10:0] hitY;
  logic [15:0] score;

  int n_checks = 0;
  int n_pass   = 0;

  player_shot_collision_detector dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .newGame      (newGame),
    .playerShotDR (playerShotDR),
    .aliensDR     (aliensDR),
    .alienType    (alienType),
    .shieldsDR    (shieldsDR),
    .topBorderDR  (topBorderDR),
    .fireCollision(fireCollision),
    .alienHit     (alienHit),
    .shieldHit    (shieldHit),
    .hitX         (hitX),
    .hitY         (hitY),
    .score        (score)
  );

  always #5 clk = ~clk;

  // Reference model: a pending hit record, a decimal integer score and the
  // published outputs.
  bit          m_pend;
  int          m_kind;    // 0 alien, 1 shield, 2 border
  int          m_type;
  logic [10:0] m_px, m_py;
  bit          m_fire, m_alien, m_shield;
  logic [10:0] m_hx, m_hy;
  int          m_score;

  function automatic int points(input int t);
    return (t == 3) ? 50 : (t + 1) * 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  logic [40:0] dut_vec;
  assign dut_vec = {fireCollision, alienHit, shieldHit, hitX, hitY, score};

  function automatic logic [40:0] exp_vec();
    return {m_fire, m_alien, m_shield, m_hx, m_hy, to_bcd(m_score)};
  endfunction

  task automatic model_clear();
    m_pend = 0; m_kind = 0; m_type = 0; m_px = '0; m_py = '0;
    m_fire = 0; m_alien = 0; m_shield = 0; m_hx = '0; m_hy = '0; m_score = 0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT
  // and return #1 after the edge.
  task automatic step();
    bit ov;
    ov = playerShotDR && (aliensDR || shieldsDR || topBorderDR);
    m_fire = 0;
    if (newGame) begin
      m_score = 0; m_pend = 0; m_alien = 0; m_shield = 0;
    end else begin
      if (startOfFrame) begin
        if (m_pend) begin
          m_fire   = 1;
          m_alien  = (m_kind == 0);
          m_shield = (m_kind == 1);
          m_hx = m_px; m_hy = m_py;
          if (m_kind == 0) begin
            m_score = m_score + points(m_type);
            if (m_score > 9999) m_score = 9999;
          end
          m_pend = 0;
        end else begin
          m_alien = 0; m_shield = 0;
        end
      end
      if (ov && !m_pend) begin
        m_pend = 1;
        m_kind = aliensDR ? 0 : (shieldsDR ? 1 : 2);
        m_type = int'(alienType);
        m_px = pixelX; m_py = pixelY;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    startOfFrame = 0; newGame = 0; playerShotDR = 0; aliensDR = 0;
    shieldsDR = 0; topBorderDR = 0; alienType = 0; pixelX = 0; pixelY = 0;
  endtask

  task automatic overlap(input bit a, input bit s, input bit b, input int t,
                         input int x, input int y);
    idle();
    playerShotDR = 1; aliensDR = a; shieldsDR = s; topBorderDR = b;
    alienType = 2'(t); pixelX = 11'(x); pixelY = 11'(y);
    step();
    idle();
  endtask

  task automatic sof();
    idle();
    startOfFrame = 1;
    step();
    idle();
  endtask

  task automatic new_game();
    idle();
    newGame = 1;
    step();
    idle();
  endtask

  task automatic alien_frame(input int t);
    overlap(1, 0, 0, t, 10, 20);
    step();
    sof();
  endtask

  task automatic test_reset();
    idle();
    resetN = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== 41'd0) $display("FAIL reset_outputs: got %h want 0", dut_vec);
    else n_pass++;
    resetN = 1;
    step();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_alien_hit();
    overlap(1, 0, 0, 1, 100, 200);
    step();
    n_checks++;
    if (fireCollision !== 1'b0) $display("FAIL alien_no_early_fire: got %b want 0", fireCollision);
    else n_pass++;
    sof();
    n_checks++;
    if ({fireCollision, alienHit, shieldHit} !== 3'b110)
      $display("FAIL alien_flags: got %b want 110", {fireCollision, alienHit, shieldHit});
    else n_pass++;
    n_checks++;
    if (hitX !== 11'd100 || hitY !== 11'd200)
      $display("FAIL alien_coords: got %0d,%0d want 100,200", hitX, hitY);
    else n_pass++;
    n_checks++;
    if (score !== 16'h0020) $display("FAIL alien_score: got %h want 0020", score);
    else n_pass++;
    step();
    n_checks++;
    if (fireCollision !== 1'b0 || alienHit !== 1'b1)
      $display("FAIL alien_pulse_width: got fire=%b alien=%b want 0,1", fireCollision, alienHit);
    else n_pass++;
  endtask

  task automatic test_two_hits();
    overlap(0, 1, 0, 0, 50, 300);
    step();
    overlap(1, 0, 0, 3, 50, 150);
    step();
    sof();
    n_checks++;
    if ({fireCollision, alienHit, shieldHit} !== 3'b101 || hitY !== 11'd300)
      $display("FAIL two_hits_first_wins: got %b y=%0d want 101 y=300",
               {fireCollision, alienHit, shieldHit}, hitY);
    else n_pass++;
    n_checks++;
    if (score !== 16'h0020) $display("FAIL two_hits_score: got %h want 0020", score);
    else n_pass++;
  endtask

  task automatic test_priority_border();
    overlap(1, 1, 1, 0, 7, 8);
    sof();
    n_checks++;
    if ({fireCollision, alienHit, shieldHit} !== 3'b110 || score !== 16'h0030)
      $display("FAIL priority_alien: got %b score=%h want 110 score=0030",
               {fireCollision, alienHit, shieldHit}, score);
    else n_pass++;
    overlap(0, 0, 1, 2, 400, 5);
    sof();
    n_checks++;
    if ({fireCollision, alienHit, shieldHit} !== 3'b100 || score !== 16'h0030 || hitX !== 11'd400)
      $display("FAIL border_hit: got %b score=%h x=%0d want 100 score=0030 x=400",
               {fireCollision, alienHit, shieldHit}, score, hitX);
    else n_pass++;
  endtask

  task automatic test_bcd_saturation();
    new_game();
    for (int i = 0; i < 33; i++) alien_frame(2);
    n_checks++;
    if (score !== 16'h0990) $display("FAIL bcd_setup_990: got %h want 0990", score);
    else n_pass++;
    alien_frame(3);
    n_checks++;
    if (score !== 16'h1040) $display("FAIL bcd_carry: got %h want 1040", score);
    else n_pass++;
    new_game();
    for (int i = 0; i < 199; i++) alien_frame(3);
    alien_frame(2);
    n_checks++;
    if (score !== 16'h9980) $display("FAIL bcd_setup_9980: got %h want 9980", score);
    else n_pass++;
    alien_frame(2);
    n_checks++;
    if (score !== 16'h9999) $display("FAIL bcd_saturate: got %h want 9999", score);
    else n_pass++;
    alien_frame(0);
    n_checks++;
    if (score !== 16'h9999) $display("FAIL bcd_stay_saturated: got %h want 9999", score);
    else n_pass++;
  endtask

  task automatic test_frame_boundary();
    new_game();
    idle();
    startOfFrame = 1; playerShotDR = 1; aliensDR = 1; alienType = 2'd1;
    pixelX = 11'd33; pixelY = 11'd44;
    step();
    idle();
    n_checks++;
    if (fireCollision !== 1'b0) $display("FAIL boundary_no_pulse: got %b want 0", fireCollision);
    else n_pass++;
    step();
    sof();
    n_checks++;
    if (fireCollision !== 1'b1 || hitX !== 11'd33 || hitY !== 11'd44 || score !== 16'h0020)
      $display("FAIL boundary_next_frame: got fire=%b %0d,%0d score=%h want 1 33,44 0020",
               fireCollision, hitX, hitY, score);
    else n_pass++;
  endtask

  task automatic test_new_game();
    overlap(1, 0, 0, 3, 1, 2);
    idle();
    newGame = 1; startOfFrame = 1;
    step();
    idle();
    n_checks++;
    if (score !== 16'h0000 || fireCollision !== 1'b0 || alienHit !== 1'b0)
      $display("FAIL newgame_clear: got score=%h fire=%b alien=%b want 0000 0 0",
               score, fireCollision, alienHit);
    else n_pass++;
    sof();
    n_checks++;
    if (fireCollision !== 1'b0) $display("FAIL newgame_pending_dropped: got %b want 0", fireCollision);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    alien_frame(1);
    overlap(0, 1, 0, 0, 9, 9);
    #2;
    resetN = 0;
    #1;
    model_clear();
    n_checks++;
    if (dut_vec !== 41'd0) $display("FAIL async_reset: got %h want 0", dut_vec);
    else n_pass++;
    @(negedge clk);
    resetN = 1;
    idle();
    sof();
    n_checks++;
    if (fireCollision !== 1'b0) $display("FAIL reset_hit_lost: got %b want 0", fireCollision);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      startOfFrame = ($urandom % 16) == 0;
      newGame      = ($urandom % 300) == 0;
      playerShotDR = ($urandom % 3) == 0;
      aliensDR     = ($urandom % 3) == 0;
      shieldsDR    = ($urandom % 4) == 0;
      topBorderDR  = ($urandom % 6) == 0;
      alienType    = 2'($urandom);
      pixelX       = 11'($urandom);
      pixelY       = 11'($urandom);
      step();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        if (errs < 10)
          $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec, exp_vec());
        errs++;
      end else begin
        n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    resetN = 1;
    model_clear();
    #1;
    test_reset();
    test_alien_hit();
    test_two_hits();
    test_priority_border();
    test_bcd_saturation();
    test_frame_boundary();
    test_new_game();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/player_shot_collision_detector.md
# player_shot_collision_detector

Per-frame collision arbiter directly downstream of the player shot drawing stage. It consumes the shot's drawing request together with the alien, shield and top-border drawing requests during the raster scan and latches the first overlap of the frame. At the next frame boundary it issues the single-cycle `fireCollision` pulse that kills the shot, reports what was hit and where, and accumulates the 4-digit BCD score.

## Interface
- No parameters. Point values are fixed: alienType 0 → 10, 1 → 20, 2 → 30, 3 (mystery ship) → 50.
- clk  in  1  system clock. One clock domain.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle frame boundary strobe.
- pixelX  in  11  current raster X.
- pixelY  in  11  current raster Y.
- newGame  in  1  one-cycle pulse that clears the score and any pending hit.
- playerShotDR  in  1  player shot drawing request. Already gated by shot alive.
- aliensDR  in  1  any alien pixel at the current raster position.
- alienType  in  2  type of the alien under the raster. Valid when aliensDR is high.
- shieldsDR  in  1  shield pixel at the current raster position.
- topBorderDR  in  1  top border pixel at the current raster position.
- fireCollision  out  1  one-cycle pulse: the shot collided during the previous frame.
- alienHit  out  1  held for the frame: the last collision was an alien.
- shieldHit  out  1  held for the frame: the last collision was a shield.
- hitX  out  11  pixelX of the first overlap pixel. Held until the next collision.
- hitY  out  11  pixelY of the first overlap pixel. Held until the next collision.
- score  out  16  4-digit BCD score, [15:12] most significant digit.

## Operation
- Two states: SCAN and LOCKED.
- In SCAN, an overlap on a cycle (playerShotDR & (aliensDR | shieldsDR | topBorderDR)) does the following:
  - Registers pendKind (ALIEN / SHIELD / BORDER), pendType, and pixelX/pixelY.
  - Moves the block to LOCKED.
- If several targets overlap on the same pixel, priority is alien > shield > border.
- LOCKED ignores all further overlaps until the frame boundary. The first overlap in raster order wins.
- On a cycle with startOfFrame=1, with a pending hit:
  - fireCollision=1 on the next cycle only.
  - alienHit and shieldHit take their values from pendKind. Both are 0 for BORDER.
  - hitX/hitY take the captured coordinates.
  - If pendKind is ALIEN, the score adds the points for pendType.
  - The block returns to SCAN.
- On a cycle with startOfFrame=1 and no pending hit: alienHit=0, shieldHit=0, fireCollision=0. hitX/hitY hold.
- An overlap on the same cycle as startOfFrame belongs to the new frame. It is registered into SCAN after the transfer.
- Score arithmetic:
  - Per-digit BCD add, with decimal carry from units through thousands.
  - Saturates at 9999. If the sum would exceed 9999, score becomes 16'h9999 and stays there.
- newGame has priority over everything on its cycle:
  - score=0, state=SCAN, pending cleared.
  - alienHit=0, shieldHit=0, fireCollision=0.
  - A simultaneous startOfFrame transfer is discarded.

## Timing
- Reset values of all outputs: fireCollision 0, alienHit 0, shieldHit 0, hitX 0, hitY 0, score 16'h0000. Internal state: SCAN, nothing pending.
- Overlap at cycle N: captured at the N+1 edge.
- startOfFrame at cycle F: fireCollision, alienHit, shieldHit, hitX, hitY and score are all updated at the F+1 edge. fireCollision drops at F+2.
- The shot mover sees fireCollision during the first cycle of the new frame, before the shot moves.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset asserted mid-frame: all state and outputs are cleared immediately. The captured hit is lost.

## Test plan
- Type 1 alien hit:
  - Stimulus: shot DR and aliensDR both high at (100,200), alienType=1, then startOfFrame.
  - Required: one-cycle fireCollision, alienHit=1, hitX=100, hitY=200, score=0x0020.
- Two hits in one frame:
  - Stimulus: shield overlap at (50,300), then alien overlap at (50,150) later in the same frame.
  - Required: shieldHit=1, alienHit=0, hitY=300, score unchanged.
- Same-pixel priority and border hit:
  - Stimulus: aliensDR and shieldsDR both high on the same overlap pixel.
  - Required: alienHit=1.
  - Stimulus: border-only overlap.
  - Required: fireCollision=1, alienHit=0, shieldHit=0, no score change.
- BCD carry and saturation:
  - Stimulus: score 0x0990, mystery (type 3) hit.
  - Required: score 0x1040.
  - Stimulus: score 0x9980, type 2 hit.
  - Required: score 0x9999. A further hit keeps 0x9999.
- Frame-boundary overlap:
  - Stimulus: overlap on the exact startOfFrame cycle.
  - Required: no pulse this frame. The pulse appears after the following startOfFrame.
- newGame and reset:
  - Stimulus: newGame together with startOfFrame while a hit is pending.
  - Required: score 0, no fireCollision.
  - Stimulus: resetN low mid-frame.
  - Required: all outputs 0 asynchronously.
